// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and coefficient/product types.
package kyber_pkg;

  localparam int KYBER_Q      = 3329;
  localparam int KYBER_COEF_W = 12;
  localparam int KYBER_PROD_W = 24;
  localparam int BARRETT_K    = 26;
  localparam int BARRETT_M    = 20158;

  typedef logic [KYBER_COEF_W-1:0] coef_t;
  typedef logic [KYBER_PROD_W-1:0] prod_t;

endpackage

// File: rtl/red_k_barrett_if.sv
// Operand/result stream between the coefficient multiplier and the Barrett reducer.
interface red_k_barrett_if;
  import kyber_pkg::*;

  logic  valid_i;
  prod_t product_i;
  logic  valid_o;
  coef_t result_o;

  modport master (output valid_i, output product_i, input valid_o, input result_o);
  modport slave  (input valid_i, input product_i, output valid_o, output result_o);

endinterface

// File: rtl/red_k_csub.sv
// Combinational conditional subtractor: y = (a >= Q) ? a - Q : a.
module red_k_csub
  import kyber_pkg::*;
#(
  parameter int W = 14,
  parameter int Q = KYBER_Q
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = (a >= W'(Q)) ? a - W'(Q) : a;

endmodule

// File: rtl/red_k_barrett.sv
// Two-stage Barrett reducer x mod 3329 for 24-bit products.
// Optional input register stage (latency 3) enabled by RED_K_INPUT_REG_EN.
module red_k_barrett
  import kyber_pkg::*;
#(
  parameter int Q         = KYBER_Q,
  parameter int IN_W      = KYBER_PROD_W,
  parameter int OUT_W     = KYBER_COEF_W,
  parameter int BARRETT_K = kyber_pkg::BARRETT_K,
  parameter int BARRETT_M = kyber_pkg::BARRETT_M
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  red_k_barrett_if.slave  bus
);

  localparam int M_W = 15;
  localparam int P_W = IN_W + M_W;
  localparam int T_W = P_W - BARRETT_K;
  // r lies in [0, 3Q) so 14 bits suffice; x - t*Q is exact modulo 2^R_W.
  localparam int R_W = 14;

  logic            v0;
  logic [IN_W-1:0] x0;

`ifdef RED_K_INPUT_REG_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v0 <= 1'b0;
      x0 <= '0;
    end else begin
      v0 <= bus.valid_i;
      x0 <= bus.product_i;
    end
  end
`else
  assign v0 = bus.valid_i;
  assign x0 = bus.product_i;
`endif

  logic [P_W-1:0] prod;
  logic [T_W-1:0] t_d;

  assign prod = P_W'(x0) * P_W'(BARRETT_M);
  assign t_d  = T_W'(prod >> BARRETT_K);

  logic           v1;
  logic [R_W-1:0] x1;
  logic [T_W-1:0] t1;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1 <= 1'b0;
      x1 <= '0;
      t1 <= '0;
    end else begin
      v1 <= v0;
      x1 <= R_W'(x0);
      t1 <= t_d;
    end
  end

  logic [R_W-1:0] tq;
  logic [R_W-1:0] r0;
  logic [R_W-1:0] r1;
  logic [R_W-1:0] r2;

  assign tq = R_W'(t1) * R_W'(Q);
  assign r0 = x1 - tq;

  red_k_csub #(.W(R_W), .Q(Q)) u_csub0 (.a(r0), .y(r1));
  red_k_csub #(.W(R_W), .Q(Q)) u_csub1 (.a(r1), .y(r2));

  logic             v2;
  logic [OUT_W-1:0] res2;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v2   <= 1'b0;
      res2 <= '0;
    end else begin
      v2   <= v1;
      res2 <= OUT_W'(r2);
    end
  end

  assign bus.valid_o  = v2;
  assign bus.result_o = res2;

endmodule

// File: tb/tb_red_k_barrett.sv
// Scoreboard bench for red_k_barrett: directed vectors, boundaries, correction sweep,
// random, gapped and mid-stream reset scenarios; latency follows RED_K_INPUT_REG_EN.
module tb_red_k_barrett;
  import kyber_pkg::*;

`ifdef RED_K_INPUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rst_n;

  red_k_barrett_if bus ();

  red_k_barrett dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int unsigned   exp_q[$];
  logic [LAT-1:0] vsh = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus with an explicit expected residue, then check outputs.
  task automatic step_exp(input logic v, input logic [23:0] x, input int unsigned exp_r);
    int unsigned e;
    bus.valid_i   = v;
    bus.product_i = x;
    if (v) exp_q.push_back(exp_r);
    @(posedge clk);
    #1;
    vsh = {vsh[LAT-2:0], v};
    check("valid_o", 32'(bus.valid_o), 32'(vsh[LAT-1]));
    if (bus.valid_o === 1'b1) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result_o", 32'(bus.result_o), e);
      end
    end
  endtask

  task automatic step(input logic v, input logic [23:0] x);
    step_exp(v, x, int'(x) % KYBER_Q);
  endtask

  initial begin
    bus.valid_i   = 1'b0;
    bus.product_i = '0;
    rst_n = 1'b0;
    #1;
    check("rst_valid_o", 32'(bus.valid_o), 32'd0);
    check("rst_result_o", 32'(bus.result_o), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Spec vectors back-to-back with hard-coded residues.
    step_exp(1'b1, 24'h631686, 2280);
    step_exp(1'b1, 24'h07AC64, 205);
    step_exp(1'b1, 24'h60EDCC, 600);
    repeat (LAT + 1) step(1'b0, 24'h0);

    // Boundaries.
    step_exp(1'b1, 24'd0, 0);
    step_exp(1'b1, 24'd3328, 3328);
    step_exp(1'b1, 24'd3329, 0);
    step_exp(1'b1, 24'd6658, 0);
    step_exp(1'b1, 24'hFFFFFF, 2384);
    repeat (LAT) step(1'b0, 24'h0);

    // Correction-path sweep: largest residue in every quotient bucket.
    for (int k = 0; k <= 3328; k++) step_exp(1'b1, 24'(3329 * k + 3328), 3328);

    // Random operands against the reference model.
    for (int i = 0; i < 300; i++) step(1'b1, 24'($urandom));
    repeat (LAT) step(1'b0, 24'h0);

    // Gapped stream 1,0,1,1,0,1.
    step(1'b1, 24'($urandom));
    step(1'b0, 24'($urandom));
    step(1'b1, 24'($urandom));
    step(1'b1, 24'($urandom));
    step(1'b0, 24'($urandom));
    step(1'b1, 24'($urandom));
    repeat (LAT) step(1'b0, 24'h0);

    // Asynchronous reset mid-stream.
    step(1'b1, 24'h123456);
    step(1'b1, 24'hABCDEF);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid_o", 32'(bus.valid_o), 32'd0);
    check("async_rst_result_o", 32'(bus.result_o), 32'd0);
    exp_q.delete();
    vsh = '0;
    bus.valid_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 24'h765432);
    step(1'b0, 24'h0);
    repeat (LAT) step(1'b0, 24'h0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
